alu_serial_rx: RTL and testbench

Serial front end of the ALU datapath. It deserializes the `sin` stream into 11-bit packets, collects 8 DATA packets (B then A, MSB byte first) and one CMD packet, and checks packet count, CRC4 and opcode. It presents one decoded command (A, B, op) or an error code to the ALU core through a valid/ready handshake. It sits directly upstream of the ALU core and consumes exactly the stream the testbench BFM drives.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_rx_packet.sv | 64 ++++++
 rtl/alu_serial_rx.sv | 93 +++++++++
 tb/tb_alu_serial_rx.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, constants and CRC4 helper for the ALU serial front end
package alu_pkg;

    localparam int N_DATA_PKT = 8;
    localparam int PKT_BITS   = 11;
    localparam int BYTE_BITS  = PKT_BITS - 3;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic {
        PKT_DATA = 1'b0,
        PKT_CMD  = 1'b1
    } packet_type_t;

    // One-hot error codes as presented on out_err_code
    typedef enum logic [2:0] {
        ERR_NONE = 3'b000,
        ERR_OP   = 3'b001,
        ERR_CRC  = 3'b010,
        ERR_DATA = 3'b100
    } processing_error_t;

    // Polynomial x^4 + x + 1, MSB-first over all 68 input bits
    function automatic logic [3:0] crc4_d68(input logic [67:0] data, input logic [3:0] seed);
        logic [3:0] c;
        logic       fb;
        c = seed;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ data[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic is_valid_op(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rx_packet.sv
// rtl/alu_rx_packet.sv - bit-level receiver turning the sin stream into typed byte packets
module alu_rx_packet
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sin,
    output logic         pkt_valid,
    output packet_type_t pkt_type,
    output logic [7:0]   pkt_byte,
    output logic         frame_err
);

    typedef enum logic [2:0] {S_IDLE, S_TYPE, S_BYTE, S_STOP, S_RESYNC} state_t;

    state_t       state;
    logic [2:0]   bit_cnt;
    logic [7:0]   shreg;
    packet_type_t type_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            type_q    <= PKT_DATA;
            pkt_valid <= 1'b0;
            pkt_type  <= PKT_DATA;
            pkt_byte  <= '0;
            frame_err <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: if (sin == START_BIT) state <= S_TYPE;
                S_TYPE: begin
                    type_q  <= packet_type_t'(sin);
                    bit_cnt <= 3'(BYTE_BITS - 1);
                    state   <= S_BYTE;
                end
                S_BYTE: begin
                    shreg <= {shreg[6:0], sin};
                    if (bit_cnt == 3'd0) state <= S_STOP;
                    else                 bit_cnt <= bit_cnt - 3'd1;
                end
                S_STOP: begin
                    // Returning straight to IDLE lets a start bit follow the stop bit directly
                    if (sin == STOP_BIT) begin
                        pkt_valid <= 1'b1;
                        pkt_type  <= type_q;
                        pkt_byte  <= shreg;
                        state     <= S_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= S_RESYNC;
                    end
                end
                S_RESYNC: if (sin == STOP_BIT) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_serial_rx.sv
// rtl/alu_serial_rx.sv - command assembly, integrity checks and output handshake register
module alu_serial_rx
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_A,
    output logic [31:0] out_B,
    output logic [2:0]  out_op,
    output logic        out_err,
    output logic [2:0]  out_err_code,
    output logic        overrun,
    output logic        frame_err
);

    logic              pkt_valid;
    packet_type_t      pkt_type;
    logic [7:0]        pkt_byte;
    logic [63:0]       ba;
    logic [3:0]        data_cnt;
    logic              extra;
    logic [2:0]        cmd_op;
    logic [3:0]        cmd_crc;
    processing_error_t cmd_err;

    alu_rx_packet u_packet (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .pkt_valid (pkt_valid),
        .pkt_type  (pkt_type),
        .pkt_byte  (pkt_byte),
        .frame_err (frame_err)
    );

    // Checks evaluated against the CMD byte while it is being committed
    always_comb begin
        cmd_op  = pkt_byte[6:4];
        cmd_crc = pkt_byte[3:0];
        cmd_err = ERR_NONE;
        if (data_cnt != 4'(N_DATA_PKT) || extra)
            cmd_err = ERR_DATA;
        else if (cmd_crc != crc4_d68({ba, 1'b1, cmd_op}, 4'b0000))
            cmd_err = ERR_CRC;
        else if (!is_valid_op(cmd_op))
            cmd_err = ERR_OP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ba           <= '0;
            data_cnt     <= '0;
            extra        <= 1'b0;
            out_valid    <= 1'b0;
            out_A        <= '0;
            out_B        <= '0;
            out_op       <= '0;
            out_err      <= 1'b0;
            out_err_code <= '0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (pkt_valid && pkt_type == PKT_DATA) begin
                if (data_cnt < 4'(N_DATA_PKT)) begin
                    ba       <= {ba[55:0], pkt_byte};
                    data_cnt <= data_cnt + 4'd1;
                end else begin
                    extra <= 1'b1;
                end
            end
            if (pkt_valid && pkt_type == PKT_CMD) begin
                data_cnt <= '0;
                extra    <= 1'b0;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    out_valid    <= 1'b1;
                    out_A        <= ba[31:0];
                    out_B        <= ba[63:32];
                    out_op       <= cmd_op;
                    out_err      <= (cmd_err != ERR_NONE);
                    out_err_code <= cmd_err;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// tb/tb_alu_serial_rx.sv - scoreboard bench for alu_serial_rx
module tb_alu_serial_rx;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [31:0] out_A;
    logic [31:0] out_B;
    logic [2:0]  out_op;
    logic        out_err;
    logic [2:0]  out_err_code;
    logic        overrun;
    logic        frame_err;

    alu_serial_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sin          (sin),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_A        (out_A),
        .out_B        (out_B),
        .out_op       (out_op),
        .out_err      (out_err),
        .out_err_code (out_err_code),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [2:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;
    int          ovr_cnt = 0;
    int          ferr_cnt = 0;
    logic        ok;
    int          lat;
    logic [31:0] ga, gb;
    logic [2:0]  gop, gcode;
    logic        gerr;

    always @(negedge clk) begin
        if (overrun)   ovr_cnt++;
        if (frame_err) ferr_cnt++;
    end

    // Independent reference: remainder of data * x^4 divided by x^4 + x + 1
    function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        tick();
    endtask

    task automatic send_pkt(input logic t, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_data(input logic [63:0] ba, input int first, input int n);
        for (int i = first; i < first + n; i++) send_pkt(1'b0, ba[63 - 8 * i -: 8], 1'b1);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [3:0] crc);
        send_pkt(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    task automatic push_exp(input logic err, input logic [2:0] code, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] op);
        exp_t t;
        t.err = err; t.code = code; t.a = a; t.b = b; t.op = op;
        sb.push_back(t);
    endtask

    task automatic wait_accept(output logic got, output int cycles, output logic [31:0] a, output logic [31:0] b,
                               output logic [2:0] op, output logic err, output logic [2:0] code);
        got = 1'b0; cycles = 0; a = '0; b = '0; op = '0; err = 1'b0; code = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got = 1'b1; cycles = i;
                a = out_A; b = out_B; op = out_op; err = out_err; code = out_err_code;
                break;
            end
        end
        if (got) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if ({out_valid, out_A, out_B, out_op, out_err, out_err_code, overrun, frame_err} !== '0) begin
            fails++;
            $display("FAIL reset_hold: outputs=%h, expected 0",
                     {out_valid, out_A, out_B, out_op, out_err, out_err_code, overrun, frame_err});
        end
        rst_n = 1'b1;
        repeat (2) tick();
        tests++;
        if ({out_valid, out_A, out_B, out_op, out_err, out_err_code, overrun, frame_err} !== '0) begin
            fails++;
            $display("FAIL reset_release: outputs=%h, expected 0",
                     {out_valid, out_A, out_B, out_op, out_err, out_err_code, overrun, frame_err});
        end
    endtask

    task automatic test_legal();
        push_exp(1'b0, 3'b000, 32'h5, 32'h3, OP_ADD);
        send_data({32'h3, 32'h5}, 0, 8);
        send_cmd(OP_ADD, ref_crc(32'h3, 32'h5, OP_ADD));
        wait_accept(ok, lat, ga, gb, gop, gerr, gcode);
        e = sb.pop_front();
        tests++;
        if (!ok) begin fails++; $display("FAIL legal_result: got no handshake, expected err=%0d", e.err); end
        else if ({gerr, gcode} !== {e.err, e.code}) begin
            fails++; $display("FAIL legal_err: got err=%0d code=%b, expected err=%0d code=%b", gerr, gcode, e.err, e.code);
        end
        if (ok && !e.err) begin
            tests++;
            if ({ga, gb, gop} !== {e.a, e.b, e.op}) begin
                fails++; $display("FAIL legal_data: got A=%h B=%h op=%b, expected A=%h B=%h op=%b", ga, gb, gop, e.a, e.b, e.op);
            end
        end
        tests++;
        if (lat !== 1) begin fails++; $display("FAIL legal_latency: got %0d cycles, expected 1", lat); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL legal_single_cycle: out_valid=%b, expected 0", out_valid); end
    endtask

    task automatic test_short();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        push_exp(1'b1, ERR_DATA, a, b, OP_OR);
        send_data({b, a}, 0, 7);
        send_cmd(OP_OR, ref_crc(b, a, OP_OR));
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                a = $urandom; b = $urandom;
                push_exp(1'b0, 3'b000, a, b, OP_SUB);
                send_data({b, a}, 0, 8);
                send_cmd(OP_SUB, ref_crc(b, a, OP_SUB));
            end
            wait_accept(ok, lat, ga, gb, gop, gerr, gcode);
            e = sb.pop_front();
            tests++;
            if (!ok) begin fails++; $display("FAIL short_result[%0d]: got no handshake, expected err=%0d", k, e.err); end
            else if ({gerr, gcode} !== {e.err, e.code}) begin
                fails++; $display("FAIL short_err[%0d]: got err=%0d code=%b, expected err=%0d code=%b", k, gerr, gcode, e.err, e.code);
            end
            if (ok && !e.err) begin
                tests++;
                if ({ga, gb, gop} !== {e.a, e.b, e.op}) begin
                    fails++; $display("FAIL short_data: got A=%h B=%h op=%b, expected A=%h B=%h op=%b", ga, gb, gop, e.a, e.b, e.op);
                end
            end
        end
    endtask

    task automatic test_crc_and_op();
        logic [2:0] ops [3];
        ops[0] = OP_AND; ops[1] = 3'b110; ops[2] = 3'b111;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                push_exp(1'b1, ERR_CRC, 32'hFFFFFFFF, 32'h1, ops[k]);
                send_data({32'h1, 32'hFFFFFFFF}, 0, 8);
                send_cmd(ops[k], ~ref_crc(32'h1, 32'hFFFFFFFF, ops[k]));
            end else begin
                push_exp(1'b1, ERR_OP, 32'h1234, 32'h77, ops[k]);
                send_data({32'h77, 32'h1234}, 0, 8);
                send_cmd(ops[k], ref_crc(32'h77, 32'h1234, ops[k]));
            end
            wait_accept(ok, lat, ga, gb, gop, gerr, gcode);
            e = sb.pop_front();
            tests++;
            if (!ok) begin fails++; $display("FAIL crc_op_result[%0d]: got no handshake, expected code=%b", k, e.code); end
            else if ({gerr, gcode} !== {e.err, e.code}) begin
                fails++; $display("FAIL crc_op_err[%0d]: got err=%0d code=%b, expected err=%0d code=%b", k, gerr, gcode, e.err, e.code);
            end
        end
    endtask

    task automatic test_extra();
        push_exp(1'b1, ERR_DATA, 32'h9, 32'h8, OP_ADD);
        send_data({32'h8, 32'h9}, 0, 8);
        send_pkt(1'b0, 8'hAA, 1'b1);
        send_cmd(OP_ADD, ref_crc(32'h8, 32'h9, OP_ADD));
        wait_accept(ok, lat, ga, gb, gop, gerr, gcode);
        e = sb.pop_front();
        tests++;
        if (!ok) begin fails++; $display("FAIL extra_result: got no handshake, expected code=%b", e.code); end
        else if ({gerr, gcode} !== {e.err, e.code}) begin
            fails++; $display("FAIL extra_err: got err=%0d code=%b, expected err=%0d code=%b", gerr, gcode, e.err, e.code);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        int          o0;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        o0 = ovr_cnt;
        out_ready = 1'b0;
        push_exp(1'b0, 3'b000, a1, b1, OP_OR);
        send_data({b1, a1}, 0, 8);
        send_cmd(OP_OR, ref_crc(b1, a1, OP_OR));
        send_data({b2, a2}, 0, 8);
        send_cmd(OP_AND, ref_crc(b2, a2, OP_AND));
        repeat (3) tick();
        tests++;
        if ({out_valid, out_A, out_B, out_op} !== {1'b1, a1, b1, OP_OR}) begin
            fails++; $display("FAIL bp_hold: got valid=%b A=%h B=%h op=%b, expected valid=1 A=%h B=%h op=001",
                              out_valid, out_A, out_B, out_op, a1, b1);
        end
        tests++;
        if (ovr_cnt - o0 !== 1) begin fails++; $display("FAIL bp_overrun: got %0d pulses, expected 1", ovr_cnt - o0); end
        out_ready = 1'b1;
        wait_accept(ok, lat, ga, gb, gop, gerr, gcode);
        e = sb.pop_front();
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_result: got no handshake, expected A=%h", e.a); end
        else if ({gerr, ga, gb, gop} !== {e.err, e.a, e.b, e.op}) begin
            fails++; $display("FAIL bp_data: got err=%0d A=%h B=%h op=%b, expected err=%0d A=%h B=%h op=%b",
                              gerr, ga, gb, gop, e.err, e.a, e.b, e.op);
        end
        repeat (2) tick();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_dropped: out_valid=%b, expected 0", out_valid); end
    endtask

    task automatic test_frame_err();
        logic [31:0] a, b;
        int          f0;
        a = 32'hCAFE0001; b = 32'h0BADF00D;
        f0 = ferr_cnt;
        push_exp(1'b1, ERR_DATA, a, b, OP_ADD);
        send_data({b, a}, 0, 2);
        send_pkt(1'b0, 8'h5A, 1'b0);
        send_bit(1'b1);
        tests++;
        if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL frame_err_pulse: got %0d pulses, expected 1", ferr_cnt - f0); end
        send_data({b, a}, 3, 5);
        send_cmd(OP_ADD, ref_crc(b, a, OP_ADD));
        wait_accept(ok, lat, ga, gb, gop, gerr, gcode);
        e = sb.pop_front();
        tests++;
        if (!ok) begin fails++; $display("FAIL frame_err_result: got no handshake, expected code=%b", e.code); end
        else if ({gerr, gcode} !== {e.err, e.code}) begin
            fails++; $display("FAIL frame_err_code: got err=%0d code=%b, expected err=%0d code=%b", gerr, gcode, e.err, e.code);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        out_ready = 1'b0;
        send_data({32'h11, 32'h22}, 0, 8);
        send_cmd(OP_ADD, ref_crc(32'h11, 32'h22, OP_ADD));
        tick();
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: out_valid=%b, expected 1", out_valid); end
        send_data({32'h33, 32'h44}, 0, 3);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_A, out_B, out_op, out_err, out_err_code, overrun, frame_err} !== '0) begin
            fails++;
            $display("FAIL rst_mid_async: outputs=%h, expected 0",
                     {out_valid, out_A, out_B, out_op, out_err, out_err_code, overrun, frame_err});
        end
        sin = 1'b1;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        a = $urandom; b = $urandom;
        push_exp(1'b0, 3'b000, a, b, OP_SUB);
        send_data({b, a}, 0, 8);
        send_cmd(OP_SUB, ref_crc(b, a, OP_SUB));
        wait_accept(ok, lat, ga, gb, gop, gerr, gcode);
        e = sb.pop_front();
        tests++;
        if (!ok) begin fails++; $display("FAIL rst_mid_result: got no handshake, expected A=%h", e.a); end
        else if ({gerr, gcode, ga, gb, gop} !== {e.err, e.code, e.a, e.b, e.op}) begin
            fails++; $display("FAIL rst_mid_data: got err=%0d A=%h B=%h op=%b, expected err=%0d A=%h B=%h op=%b",
                              gerr, ga, gb, gop, e.err, e.a, e.b, e.op);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_legal();
        test_short();
        test_crc_and_op();
        test_extra();
        test_back_to_back();
        test_frame_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
